// File: rtl/serial_parallel_c_if.sv
// Lane interface between the serial line side and the byte-level consumer.
// The master drives the line bit; the slave (deserializer) returns bytes and status.
interface serial_parallel_c_if;
  logic       Data_in;
  logic [7:0] Data_out_c;
  logic       valid_out_c;
  logic       active_c;

  modport master (
    output Data_in,
    input  Data_out_c,
    input  valid_out_c,
    input  active_c
  );

  modport slave (
    input  Data_in,
    output Data_out_c,
    output valid_out_c,
    output active_c
  );
endinterface

// File: rtl/serial_parallel_c.sv
// Receive-side lane deserializer: finds byte alignment from the idle comma,
// locks after LOCK_COUNT aligned commas, then rebuilds bytes and flags data vs idle.
module serial_parallel_c #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input logic               clk_32f,
  input logic               reset,
  serial_parallel_c_if.slave lane
);

  localparam int unsigned BcW     = $clog2(LOCK_COUNT + 1);
  localparam logic [BcW-1:0] BcOne   = BcW'(1);
  localparam logic [BcW-1:0] BcMax   = {BcW{1'b1}};
  localparam logic [BcW-1:0] LockCnt = BcW'(LOCK_COUNT);

  typedef enum logic [1:0] {StSearch, StAlign, StLocked} state_e;

  state_e         state_q, state_d;
  // Only the low 7 bits of the shift history are ever needed to form the next byte.
  logic [6:0]     sr_q, sr_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BcW-1:0] bc_cnt_q, bc_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;

  logic [7:0]     nxt;
  logic           boundary;

  assign nxt      = {sr_q, lane.Data_in};
  assign boundary = (bit_cnt_q == 3'd7);

  // State registers with immediate (asynchronous) clear.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= StSearch;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  // Alignment FSM, bit counter and byte capture.
  always_comb begin
    state_d   = state_q;
    sr_d      = nxt[6:0];
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;

    unique case (state_q)
      StSearch: begin
        bit_cnt_d = 3'd0;
        if (nxt == COMMA) begin
          // The matching edge carries the comma LSB, so the next edge starts a byte.
          bc_cnt_d = BcOne;
          state_d  = (LOCK_COUNT == 1) ? StLocked : StAlign;
        end
      end
      StAlign: begin
        if (boundary) begin
          if (nxt == COMMA) begin
            if (bc_cnt_q != BcMax) bc_cnt_d = bc_cnt_q + BcOne;
            if ((bc_cnt_q + BcOne) == LockCnt) state_d = StLocked;
          end else begin
            bc_cnt_d = '0;
            state_d  = StSearch;
          end
        end
      end
      StLocked: begin
        if (boundary) begin
          data_d  = nxt;
          valid_d = (nxt != COMMA);
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Outputs come straight from registers; active follows the lock state.
  always_comb begin
    lane.Data_out_c  = data_q;
    lane.valid_out_c = valid_q;
    lane.active_c    = (state_q == StLocked);
  end

endmodule

// File: tb/tb_serial_parallel_c.sv
// Directed bench for serial_parallel_c: alignment, lock, byte decode and async reset.
module tb_serial_parallel_c;

  localparam logic [7:0] Bc = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  serial_parallel_c_if lane ();

  serial_parallel_c #(
    .COMMA      (8'hBC),
    .LOCK_COUNT (4)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lane    (lane.slave)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bit before the rising edge, return 1 time unit after it.
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    lane.Data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_range(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_range(b, 7, 0);
  endtask

  // Locked-lane byte: expectation queued at drive time, checked at the LSB edge.
  task automatic send_sb(input logic [7:0] b, input string tag);
    exp_t e;
    sb_q.push_back('{data: b, valid: (b != Bc)});
    send_byte(b);
    e = sb_q.pop_front();
    chk({tag, "_data"}, lane.Data_out_c, e.data);
    chk({tag, "_valid"}, {7'd0, lane.valid_out_c}, {7'd0, e.valid});
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset        = 1'b1;
    lane.Data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  initial begin
    lane.Data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    chk("rst_data", lane.Data_out_c, 8'h00);
    chk("rst_valid", {7'd0, lane.valid_out_c}, 8'd0);
    chk("rst_active", {7'd0, lane.active_c}, 8'd0);
    @(negedge clk_32f);
    reset = 1'b0;

    // Four aligned commas lock on the LSB edge of the fourth.
    for (int k = 0; k < 3; k++) begin
      send_byte(Bc);
      chk("lock_pre_active", {7'd0, lane.active_c}, 8'd0);
    end
    send_range(Bc, 7, 1);
    chk("lock_bit6_active", {7'd0, lane.active_c}, 8'd0);
    send_range(Bc, 0, 0);
    chk("lock_active", {7'd0, lane.active_c}, 8'd1);
    chk("lock_valid", {7'd0, lane.valid_out_c}, 8'd0);
    chk("lock_data", lane.Data_out_c, 8'h00);

    // Data bytes, and hold of the previous byte until the next boundary.
    send_sb(8'hA5, "a5");
    send_range(8'h3C, 7, 1);
    chk("hold_data", lane.Data_out_c, 8'hA5);
    chk("hold_valid", {7'd0, lane.valid_out_c}, 8'd1);
    sb_q.push_back('{data: 8'h3C, valid: 1'b1});
    send_range(8'h3C, 0, 0);
    begin
      exp_t e;
      e = sb_q.pop_front();
      chk("3c_data", lane.Data_out_c, e.data);
      chk("3c_valid", {7'd0, lane.valid_out_c}, {7'd0, e.valid});
    end

    // Idle interleaved with data.
    send_sb(Bc, "idle0");
    send_sb(8'h01, "d01");
    send_sb(Bc, "idle1");

    // Asynchronous reset mid-byte while locked.
    send_range(8'hA5, 7, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_data", lane.Data_out_c, 8'h00);
    chk("arst_valid", {7'd0, lane.valid_out_c}, 8'd0);
    chk("arst_active", {7'd0, lane.active_c}, 8'd0);
    @(negedge clk_32f);
    lane.Data_in = 1'b0;
    reset        = 1'b0;

    // Three commas, a non-comma byte drops back to search, then a fresh lock.
    for (int k = 0; k < 3; k++) begin
      send_byte(Bc);
      chk("brk_align_active", {7'd0, lane.active_c}, 8'd0);
    end
    send_byte(8'h55);
    chk("brk_55_active", {7'd0, lane.active_c}, 8'd0);
    chk("brk_55_valid", {7'd0, lane.valid_out_c}, 8'd0);
    for (int k = 0; k < 3; k++) begin
      send_byte(Bc);
      chk("brk_relock_pre", {7'd0, lane.active_c}, 8'd0);
    end
    send_byte(Bc);
    chk("brk_relock_active", {7'd0, lane.active_c}, 8'd1);

    // Junk bits shift the alignment; decode must follow the new offset.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 4; k++) send_byte(Bc);
    chk("shift_active", {7'd0, lane.active_c}, 8'd1);
    send_sb(8'h96, "s96");
    send_sb(8'h0F, "s0f");
    send_sb(8'h5A, "s5a");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
